// File: rtl/sram_cmd_ctrl_pkg.sv
// Shared definitions for the SRAM command controller: FSM state encoding
// and the default byte address of RAM word 0.
package sram_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RSP  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/sram_cmd_ctrl.sv
// Valid/ready command front end for a single-port synchronous SRAM.
// One response per command, latency 1, at most one outstanding.
// Optional address range checking: define SRAM_CMD_CTRL_ADDR_CHK_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no response pending
// RSP   | response presented, read data taken live from ram_dout
// HOLD  | response stalled, read data presented from hold_q
module sram_cmd_ctrl
  import sram_cmd_ctrl_pkg::*;
#(
  parameter int DP = 512,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32,
  parameter logic [AW-1:0] BASE_ADDR = AW'(DEFAULT_BASE_ADDR)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [MW-1:0] cmd_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  localparam int OW = $clog2(MW);
  localparam int IW = $clog2(DP);

  state_e        state_q;
  logic [DW-1:0] hold_q;
  logic [AW-1:0] last_rd_q;
  logic          rd_ok_q;

  logic          fire;
  logic          addr_err;
  logic [AW-1:0] offset;
  logic [AW-1:0] word_idx;
  logic [DW-1:0] rdata_d;

  // Nothing may be accepted (and so nothing written) while reset is held.
  assign fire      = rst_n & cmd_valid & cmd_ready;
  assign cmd_ready = ~rsp_valid | rsp_ready;
  assign rsp_valid = (state_q != ST_IDLE);
  assign offset    = cmd_addr - BASE_ADDR;

`ifdef SRAM_CMD_CTRL_ADDR_CHK_EN
  logic          err_q;
  logic [AW-1:0] word_full;

  assign word_full = offset >> OW;
  assign word_idx  = word_full;
  assign addr_err  = (cmd_addr < BASE_ADDR) || (word_full >= AW'(DP));
  assign rsp_err   = err_q;

  // Error flag travels with the response; cleared once it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (fire) begin
      err_q <= addr_err;
    end else if (rsp_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_offset;

  // Index wraps modulo DP; byte-lane and high offset bits are dropped.
  assign word_idx      = AW'(offset[OW +: IW]);
  assign unused_offset = ^{offset[AW-1:OW+IW], offset[OW-1:0]};
  assign addr_err      = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  // Response data: live RAM output when unstalled, captured copy when held.
  always_comb begin
    rdata_d = '0;
    if (state_q == ST_HOLD) begin
      rdata_d = hold_q;
    end else if (state_q == ST_RSP && rd_ok_q) begin
      rdata_d = ram_dout;
    end
  end

  assign rsp_rdata = rdata_d;

  // RAM drive: the accepted command this cycle, otherwise park on the last
  // read address so the RAM keeps re-reading the word a response depends on.
  always_comb begin
    ram_addr = last_rd_q;
    ram_din  = cmd_wdata;
    ram_we   = 1'b0;
    ram_wem  = '0;
    if (fire && !addr_err) begin
      ram_addr = word_idx;
      ram_we   = ~cmd_read;
      ram_wem  = cmd_wmask;
    end
  end

  // Response FSM, hold register and last-read address tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      last_rd_q <= '0;
      rd_ok_q   <= 1'b0;
    end else begin
      if (fire) begin
        rd_ok_q <= cmd_read & ~addr_err;
        if (cmd_read && !addr_err) begin
          last_rd_q <= word_idx;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (fire) state_q <= ST_RSP;
        end
        ST_RSP: begin
          if (!rsp_ready) begin
            state_q <= ST_HOLD;
            hold_q  <= rdata_d;
          end else if (!fire) begin
            state_q <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) state_q <= fire ? ST_RSP : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_cmd_ctrl.sv
// Scoreboard bench for sram_cmd_ctrl with a behavioural SRAM and a
// word-array reference model of the addressed memory.
module tb_sram_cmd_ctrl;

  localparam int          DP   = 512;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout = '0;

  logic        rdy_main = 1'b1;
  logic        rdy_rand = 1'b1;
  logic        random_ready = 1'b0;
  assign rsp_ready = random_ready ? rdy_rand : rdy_main;

  logic [31:0] ram_mem [DP];
  logic [31:0] ref_mem [DP];
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  sram_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_wem(ram_wem), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: masked write, or re-latch the read address.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) ram_mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
    end else begin
      ram_dout <= ram_mem[ram_addr[8:0]];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic bit in_range(input logic [31:0] a);
`ifdef SRAM_CMD_CTRL_ADDR_CHK_EN
    return (a >= BASE) && (((a - BASE) >> 2) < DP);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - BASE) >> 2) % DP;
    return int'(w);
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: memory as an array of words, updated per accepted command.
  function automatic exp_t model(input bit rd, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] m);
    exp_t e;
    int   i;
    e = '{rdata: 32'h0, err: 1'b0};
    if (!in_range(a)) begin
      e.err = 1'b1;
      return e;
    end
    i = widx(a);
    if (rd) begin
      e.rdata = ref_mem[i];
    end else begin
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[i][8*b +: 8] = wd[8*b +: 8];
    end
    return e;
  endfunction

  task automatic send(input bit rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    bit   fired;
    exp_t e;
    fired     = 1'b0;
    e         = '0;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = m;
    for (int t = 0; t < 100 && !fired; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        fired = 1'b1;
        e     = model(rd, a, wd, m);
      end
      @(posedge clk);
      if (fired) sb_q.push_back(e);
      #1;
    end
    if (!fired) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: addr %0h not accepted in 100 cycles", a);
    end
    cmd_valid = 1'b0;
  endtask

  // Monitor: protocol and RAM-side checks every cycle, response checks
  // against the scoreboard whenever a response is presented.
  initial begin
    bit exp_rdy;
    bit exp_fire;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_ram_we", ram_we, 0);
      end else begin
        check("rsp_valid_vs_pending", rsp_valid, sb_q.size() != 0);
        exp_rdy  = (sb_q.size() == 0) || rsp_ready;
        exp_fire = cmd_valid && exp_rdy && in_range(cmd_addr);
        check("cmd_ready", cmd_ready, exp_rdy);
        check("ram_we", ram_we, exp_fire && !cmd_read);
        if (exp_fire) check("ram_addr", ram_addr, widx(cmd_addr));
        check("ram_wem", ram_wem, exp_fire ? cmd_wmask : 4'h0);
        if (rsp_valid && sb_q.size() != 0) begin
          check("rsp_rdata", rsp_rdata, sb_q[0].rdata);
          check("rsp_err", rsp_err, sb_q[0].err);
          if (rsp_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    bit          rd;
    for (int i = 0; i < DP; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wem", ram_wem, 0);
    rst_n = 1'b1;

    // Write then read back, full mask; first command right after release
    send(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    send(1, BASE + 32'h10, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

    // Partial byte mask merge
    send(0, BASE + 32'h20, 32'h1122_3344, 4'hF);
    send(0, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    send(1, BASE + 32'h20, 32'h0, 4'h0);
    check("mask_merge_model", ref_mem[8], 32'h11BB_33DD);
    repeat (2) @(posedge clk);
    #1;

    // Stalled read with a competing write waiting
    send(0, BASE + 32'h40, 32'hCAFE_F00D, 4'hF);
    send(1, BASE + 32'h40, 32'h0, 4'h0);
    rdy_main  = 1'b0;
    cmd_valid = 1'b1;
    cmd_read  = 1'b0;
    cmd_addr  = BASE + 32'h44;
    cmd_wdata = 32'h5555_AAAA;
    cmd_wmask = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_ram_we", ram_we, 0);
      check("stall_rdata", rsp_rdata, 32'hCAFE_F00D);
      @(posedge clk);
      #1;
    end
    rdy_main = 1'b1;
    send(0, BASE + 32'h44, 32'h5555_AAAA, 4'hF);
    send(1, BASE + 32'h44, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

    // Eight back-to-back writes then eight back-to-back reads
    for (int i = 0; i < 8; i++) send(0, BASE + 32'h100 + 4 * i, $urandom, 4'hF);
    for (int i = 0; i < 8; i++) send(1, BASE + 32'h100 + 4 * i, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

`ifdef SRAM_CMD_CTRL_ADDR_CHK_EN
    // Out-of-range accesses
    send(1, BASE + 4 * DP, 32'h0, 4'h0);
    send(0, BASE + 4 * DP + 8, 32'hFFFF_FFFF, 4'hF);
    send(0, BASE - 4, 32'hFFFF_FFFF, 4'hF);
    send(1, BASE + 32'h10, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
`endif

    // Reset while a read response is stalled
    send(0, BASE + 32'h80, 32'h0BAD_CAFE, 4'hF);
    send(1, BASE + 32'h80, 32'h0, 4'h0);
    rdy_main = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_ram_we", ram_we, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_main = 1'b1;
    send(1, BASE + 32'h80, 32'h0, 4'h0);
    send(1, BASE + 32'h10, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic with random response back-pressure
    random_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rd = 1'($urandom_range(0, 1));
      a  = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) begin
`ifdef SRAM_CMD_CTRL_ADDR_CHK_EN
        if ($urandom_range(0, 1) == 1) a = BASE - 4 * $urandom_range(1, 8);
        else a = BASE + 4 * DP + 4 * $urandom_range(0, 8);
`else
        a = BASE + 4 * DP + 4 * $urandom_range(0, 31);
`endif
      end
      send(rd, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    random_ready = 1'b0;
    rdy_main     = 1'b1;
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_scoreboard", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
